// File: rtl/vdma_sched.sv
// vdma_sched: single-channel CRT DMA scheduler with CPU-programmed base address/count.
// Optional autoload on terminal count is built in when VDMA_SCHED_AUTOLOAD_EN is defined.
module vdma_sched #(
  parameter int CNT_W = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [1:0]  iaddr,
  input  logic [7:0]  idata,
  input  logic        iwe_n,
  input  logic        ird_n,
  output logic [7:0]  odata,
  input  logic        drq,
  output logic        dack,
  output logic [7:0]  ochar,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_we_d;
  logic             r_rd_d;
  logic             r_ff;
  logic             r_enable;
  logic             r_tc;
  logic [15:0]      r_base_addr;
  logic [15:0]      r_cur_addr;
  logic [15:0]      r_mem_addr;
  logic [CNT_W-1:0] r_base_cnt;
  logic [CNT_W-1:0] r_cur_cnt;
  logic [7:0]       r_ochar;
  logic             w_wr;
  logic             w_rd;
  logic             w_done;
  logic             w_tc_hit;
  logic             w_autoload;
  logic [15:0]      w_base_cnt16;

`ifdef VDMA_SCHED_AUTOLOAD_EN
  logic r_autoload;
  assign w_autoload = r_autoload;
`else
  assign w_autoload = 1'b0;
`endif

  assign w_wr         = iwe_n & ~r_we_d;
  assign w_rd         = ird_n & ~r_rd_d;
  assign w_done       = (r_state == ACK) & ce;
  assign w_tc_hit     = w_done & (r_cur_cnt == '0);
  assign w_base_cnt16 = 16'(r_base_cnt);

  assign odata    = {5'b0, r_tc, w_autoload, r_enable};
  assign ochar    = r_ochar;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (drq & r_enable) w_next = REQ;
      REQ:     if (mem_ack)        w_next = ACK;
      ACK:     if (ce)             w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    dack    = 1'b0;
    case (r_state)
      REQ:     mem_req = 1'b1;
      ACK:     dack    = 1'b1;
      default: ;
    endcase
  end

  // CPU write is applied after the transfer update so it wins on a same-cycle terminal count;
  // a tc set by a completing transfer also wins over a coincident status-read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we_d      <= 1'b1;
      r_rd_d      <= 1'b1;
      r_ff        <= 1'b0;
      r_enable    <= 1'b0;
      r_tc        <= 1'b0;
      r_base_addr <= '0;
      r_cur_addr  <= '0;
      r_mem_addr  <= '0;
      r_base_cnt  <= '0;
      r_cur_cnt   <= '0;
      r_ochar     <= '0;
`ifdef VDMA_SCHED_AUTOLOAD_EN
      r_autoload  <= 1'b0;
`endif
    end else begin
      r_we_d <= iwe_n;
      r_rd_d <= ird_n;
      if ((r_state == IDLE) && (w_next == REQ)) r_mem_addr <= r_cur_addr;
      if ((r_state == REQ) && mem_ack)          r_ochar    <= mem_data;
      if (w_rd) r_tc <= 1'b0;
      if (w_done) begin
        r_cur_addr <= r_cur_addr + 16'd1;
        r_cur_cnt  <= r_cur_cnt - CNT_W'(1);
        if (w_tc_hit) begin
          r_tc <= 1'b1;
          if (w_autoload) begin
            r_cur_addr <= r_base_addr;
            r_cur_cnt  <= r_base_cnt;
          end else begin
            r_enable <= 1'b0;
          end
        end
      end
      if (w_wr) begin
        case (iaddr)
          2'd0: begin
            if (r_ff) r_base_addr[15:8] <= idata;
            else      r_base_addr[7:0]  <= idata;
            r_ff <= ~r_ff;
          end
          2'd1: begin
            if (r_ff) r_base_cnt <= CNT_W'({idata, w_base_cnt16[7:0]});
            else      r_base_cnt <= CNT_W'({w_base_cnt16[15:8], idata});
            r_ff <= ~r_ff;
          end
          2'd2: begin
            r_ff     <= 1'b0;
            r_enable <= idata[0];
`ifdef VDMA_SCHED_AUTOLOAD_EN
            r_autoload <= idata[1];
`endif
            if (idata[0]) begin
              r_cur_addr <= r_base_addr;
              r_cur_cnt  <= r_base_cnt;
            end
          end
          default: r_ff <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdma_sched.sv
// tb_vdma_sched: vector table for mode/status plus scoreboarded transfer scenarios.
// A background process models memory latency, ce gating and records observed transfers.
module tb_vdma_sched;

  localparam int CNT_W = 14;
`ifdef VDMA_SCHED_AUTOLOAD_EN
  localparam logic [7:0] ALB = 8'h02;
`else
  localparam logic [7:0] ALB = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset, ce, iwe_n, ird_n, drq, mem_ack, dack, mem_req;
  logic [1:0]  iaddr;
  logic [7:0]  idata, odata, ochar, mem_data;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  vdma_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ce(ce), .iaddr(iaddr), .idata(idata),
    .iwe_n(iwe_n), .ird_n(ird_n), .odata(odata), .drq(drq), .dack(dack),
    .ochar(ochar), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  function automatic logic [7:0] fdat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // controls written by the test process
  logic       mem_auto, ce_div4, man_ack;
  logic [7:0] man_data;
  // observations written only by the background process
  logic [15:0] obs_addr [64];
  logic [7:0]  obs_char [64];
  int unsigned obs_an, obs_cn, dack_cnt, mon_bad;

  initial begin
    int unsigned cyc, wcnt;
    logic prev_req, prev_dack, prev_ce, prev_rst;
    logic [7:0] prev_ochar;
    ce = 1'b1; mem_ack = 1'b0; mem_data = '0;
    obs_an = 0; obs_cn = 0; dack_cnt = 0; mon_bad = 0;
    cyc = 0; wcnt = 0;
    prev_req = 1'b0; prev_dack = 1'b0; prev_ce = 1'b1; prev_rst = 1'b1; prev_ochar = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prev_req && obs_an < 64) begin
        obs_addr[obs_an] = mem_addr;
        obs_an++;
      end
      if (dack && !prev_dack) begin
        dack_cnt++;
        if (obs_cn < 64) begin
          obs_char[obs_cn] = ochar;
          obs_cn++;
        end
      end
      if (prev_dack && dack && (prev_ce || ochar != prev_ochar)) mon_bad++;
      if (prev_dack && !dack && !prev_ce && !prev_rst) mon_bad++;
      prev_req = mem_req; prev_dack = dack; prev_ochar = ochar; prev_rst = reset;
      ce = ce_div4 ? ((cyc % 4) == 0) : 1'b1;
      prev_ce = ce;
      if (mem_auto) begin
        if (mem_ack) begin
          mem_ack = 1'b0; wcnt = 0;
        end else if (mem_req) begin
          if (wcnt >= 1) begin
            mem_ack = 1'b1; mem_data = fdat(mem_addr); wcnt = 0;
          end else wcnt++;
        end else wcnt = 0;
      end else begin
        mem_ack = man_ack; mem_data = man_data;
      end
    end
  end

  int unsigned n_tests, n_fail, rd_a, rd_c;
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_char_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_x(input logic [15:0] a, input bit with_char);
    exp_addr_q.push_back(a);
    if (with_char) exp_char_q.push_back(fdat(a));
  endtask

  task automatic drain(input string name);
    logic [15:0] ea;
    logic [7:0]  ec;
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      if (rd_a < obs_an) begin
        check({name, " addr"}, 32'(obs_addr[rd_a]), 32'(ea));
        rd_a++;
      end else check({name, " missing mem_req"}, obs_an, rd_a + 1);
    end
    while (exp_char_q.size() > 0) begin
      ec = exp_char_q.pop_front();
      if (rd_c < obs_cn) begin
        check({name, " ochar"}, 32'(obs_char[rd_c]), 32'(ec));
        rd_c++;
      end else check({name, " missing dack"}, obs_cn, rd_c + 1);
    end
    check({name, " extra mem_req"}, obs_an, rd_a);
    check({name, " extra dack"}, obs_cn, rd_c);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk); iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_rd(output logic [7:0] st);
    @(negedge clk); ird_n = 1'b0;
    @(negedge clk); st = odata; ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_dacks(input int unsigned n, input string name);
    int unsigned k = 0;
    while (!(dack_cnt >= n && !dack && !mem_req) && k < 2000) begin
      @(negedge clk); k++;
    end
    check({name, " done in budget"}, 32'(k < 2000), 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int unsigned k = 0;
    while (!mem_req && k < 200) begin
      @(negedge clk); k++;
    end
    check({name, " mem_req seen"}, 32'(mem_req), 32'd1);
  endtask

  typedef struct packed { logic [1:0] a; logic [7:0] d; logic [7:0] st; } vec_t;
  vec_t vt [6];

  initial begin
    logic [7:0] st;
    int unsigned d0;
    reset = 1'b1; iaddr = '0; idata = '0; iwe_n = 1'b1; ird_n = 1'b1; drq = 1'b0;
    man_ack = 1'b0; man_data = '0; mem_auto = 1'b1; ce_div4 = 1'b0;
    n_tests = 0; n_fail = 0; rd_a = 0; rd_c = 0;
    vt[0] = '{2'd2, 8'h00, 8'h00};
    vt[1] = '{2'd2, 8'h02, ALB};
    vt[2] = '{2'd2, 8'h01, 8'h01};
    vt[3] = '{2'd2, 8'hFC, 8'h00};
    vt[4] = '{2'd2, 8'h03, 8'h01 | ALB};
    vt[5] = '{2'd2, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("reset odata", 32'(odata), 0);
    check("reset mem_req", 32'(mem_req), 0);
    check("reset dack", 32'(dack), 0);
    check("reset ochar", 32'(ochar), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      cpu_wr(vt[i].a, vt[i].d);
      check($sformatf("mode vec %0d status", i), 32'(odata), 32'(vt[i].st));
    end
    check("mode vecs no mem_req", obs_an, 0);

    // basic block of count+1 transfers
    cpu_wr(2'd0, 8'hD0); cpu_wr(2'd0, 8'h76); cpu_wr(2'd1, 8'h02); cpu_wr(2'd1, 8'h00);
    for (int i = 0; i < 3; i++) push_x(16'h76D0 + 16'(i), 1'b1);
    d0 = dack_cnt;
    cpu_wr(2'd2, 8'h01); drq = 1'b1;
    wait_dacks(d0 + 3, "basic");
    drq = 1'b0;
    drain("basic");
    check("basic status", 32'(odata), 32'h04);
    cpu_rd(st);
    check("basic status read", 32'(st), 32'h04);
    check("basic tc cleared", 32'(odata), 32'h00);

`ifdef VDMA_SCHED_AUTOLOAD_EN
    for (int i = 0; i < 3; i++) push_x(16'h76D0 + 16'(i), 1'b1);
    push_x(16'h76D0, 1'b1);
    d0 = dack_cnt;
    cpu_wr(2'd2, 8'h03); drq = 1'b1;
    begin
      int unsigned k = 0;
      while (obs_an < rd_a + 4 && k < 2000) begin @(negedge clk); k++; end
      check("auto 4th req in budget", 32'(k < 2000), 32'd1);
    end
    drq = 1'b0;
    wait_dacks(d0 + 4, "auto");
    drain("auto");
    check("auto status", 32'(odata), 32'h07);
    cpu_rd(st);
    check("auto status read", 32'(st), 32'h07);
    check("auto tc cleared", 32'(odata), 32'h03);
    cpu_wr(2'd2, 8'h00);
    check("auto disabled", 32'(odata), 32'h00);
`else
    for (int i = 0; i < 3; i++) push_x(16'h76D0 + 16'(i), 1'b1);
    d0 = dack_cnt;
    cpu_wr(2'd2, 8'h03); drq = 1'b1;
    wait_dacks(d0 + 3, "noauto");
    drq = 1'b0;
    drain("noauto");
    check("noauto status", 32'(odata), 32'h04);
    cpu_rd(st);
    check("noauto tc cleared", 32'(odata), 32'h00);
`endif

    // ce gating: ce high one cycle in four
    @(posedge clk); #1 ce_div4 = 1'b1;
    for (int i = 0; i < 3; i++) push_x(16'h76D0 + 16'(i), 1'b1);
    d0 = dack_cnt;
    cpu_wr(2'd2, 8'h01); drq = 1'b1;
    wait_dacks(d0 + 3, "ce");
    drq = 1'b0;
    @(posedge clk); #1 ce_div4 = 1'b0;
    drain("ce");
    check("ce dack protocol", mon_bad, 0);
    check("ce status", 32'(odata), 32'h04);
    cpu_rd(st);

    // address wrap with flip-flop clear between byte writes
    cpu_wr(2'd0, 8'h34); cpu_wr(2'd3, 8'h00); cpu_wr(2'd0, 8'hFF); cpu_wr(2'd0, 8'hFF);
    cpu_wr(2'd1, 8'h01); cpu_wr(2'd1, 8'h00);
    push_x(16'hFFFF, 1'b1); push_x(16'h0000, 1'b1);
    d0 = dack_cnt;
    cpu_wr(2'd2, 8'h01); drq = 1'b1;
    wait_dacks(d0 + 2, "wrap");
    drq = 1'b0;
    drain("wrap");
    check("wrap status", 32'(odata), 32'h04);
    cpu_rd(st);

    // flip-flop clear observed through the next address; count 0 gives one byte
    cpu_wr(2'd0, 8'h34); cpu_wr(2'd3, 8'h00); cpu_wr(2'd0, 8'h56); cpu_wr(2'd0, 8'h12);
    cpu_wr(2'd1, 8'h00); cpu_wr(2'd1, 8'h00);
    push_x(16'h1256, 1'b1);
    d0 = dack_cnt;
    cpu_wr(2'd2, 8'h01); drq = 1'b1;
    wait_dacks(d0 + 1, "ff");
    drq = 1'b0;
    drain("ff");
    check("ff status", 32'(odata), 32'h04);
    cpu_rd(st);

    // reset while in REQ with a coincident mem_ack
    @(posedge clk); #1 mem_auto = 1'b0;
    cpu_wr(2'd2, 8'h01);
    push_x(16'h1256, 1'b0);
    d0 = dack_cnt;
    drq = 1'b1;
    wait_req("rst");
    @(posedge clk); #1 man_ack = 1'b1; man_data = 8'h3C; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    check("rst mem_req", 32'(mem_req), 0);
    check("rst dack", 32'(dack), 0);
    check("rst ochar", 32'(ochar), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst status", 32'(odata), 0);
    repeat (10) @(negedge clk);
    check("rst no dack", dack_cnt, d0);
    drq = 1'b0;
    drain("rst");

    // disable and drq drop while in REQ
    cpu_wr(2'd0, 8'h00); cpu_wr(2'd0, 8'h40); cpu_wr(2'd1, 8'h05); cpu_wr(2'd1, 8'h00);
    cpu_wr(2'd2, 8'h01);
    push_x(16'h4000, 1'b1);
    d0 = dack_cnt;
    drq = 1'b1;
    wait_req("dis");
    drq = 1'b0;
    cpu_wr(2'd2, 8'h00);
    check("dis still in REQ", 32'(mem_req), 1);
    check("dis status", 32'(odata), 0);
    @(posedge clk); #1 man_data = fdat(16'h4000); man_ack = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0;
    repeat (20) @(negedge clk);
    check("dis one dack", dack_cnt - d0, 1);
    check("dis idle", 32'(mem_req), 0);
    drain("dis");
    check("dack protocol overall", mon_bad, 0);
    @(posedge clk); #1 mem_auto = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
